game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl_if.sv | 39 +++
 rtl/game_flow_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl bus: frame/button controls, datapath next-state inputs and
// the registered game state fed back to the datapath and display.
// slave  = controller side, master = driver/datapath side.
interface game_flow_ctrl_if;
    logic          tick;
    logic          launch;
    logic [9:0]    board_x;
    logic [1439:0] init_bricks;
    logic [1439:0] nxt_bricks;
    logic [9:0]    nxt_x;
    logic [9:0]    nxt_y;
    logic [9:0]    nxt_vx;
    logic [9:0]    nxt_vy;
    logic [1:0]    nxt_dir;
    logic [1439:0] bricks;
    logic [9:0]    ball_x;
    logic [9:0]    ball_y;
    logic [9:0]    ball_vx;
    logic [9:0]    ball_vy;
    logic [1:0]    ball_dir;
    logic [1:0]    lives;
    logic [2:0]    state;
    logic          game_over;
    logic          game_win;

    modport slave (
        input  tick, launch, board_x, init_bricks, nxt_bricks,
               nxt_x, nxt_y, nxt_vx, nxt_vy, nxt_dir,
        output bricks, ball_x, ball_y, ball_vx, ball_vy, ball_dir,
               lives, state, game_over, game_win
    );

    modport master (
        output tick, launch, board_x, init_bricks, nxt_bricks,
               nxt_x, nxt_y, nxt_vx, nxt_vy, nxt_dir,
        input  bricks, ball_x, ball_y, ball_vx, ball_vy, ball_dir,
               lives, state, game_over, game_win
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: breakout game flow FSM. Owns the registered ball state,
// brick map and lives; commits the datapath's nxt_* step on each RUN tick.
// Optional build macro GAME_FLOW_SPEEDUP_EN: every 512 committed steps the
// ball speed is raised by one, capped at 8.
module game_flow_ctrl #(
    parameter int H       = 640,
    parameter int V       = 480,
    parameter int BALL_W  = 16,
    parameter int BALL_H  = 10,
    parameter int BOARD_Y = 467,
    parameter int INIT_V  = 2,
    parameter int LIVES   = 3
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RUN   = 3'd2,
        S_LOSE  = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    localparam logic [9:0] LOSE_Y  = 10'(V - BALL_H);
    localparam logic [9:0] SERVE_Y = 10'(BOARD_Y - BALL_H);
    localparam logic [9:0] SERVE_V = 10'(INIT_V);
    localparam logic [1:0] LIVES_Q = 2'(LIVES);

    // Screen geometry must fit the 10-bit coordinate space.
    if (H > 1024 || V > 1024 || BALL_W > H || BALL_H > V) begin : g_bad_geom
        $error("game_flow_ctrl: geometry does not fit 10-bit coordinates");
    end

    state_t          r_state;
    state_t          w_next;
    logic [1439:0]   r_bricks;
    logic [9:0]      r_ball_x;
    logic [9:0]      r_ball_y;
    logic [9:0]      r_ball_vx;
    logic [9:0]      r_ball_vy;
    logic [1:0]      r_ball_dir;
    logic [1:0]      r_lives;
    logic            r_game_over;
    logic            r_game_win;

    logic            w_bricks_empty;
    logic            w_loss;
    logic            w_step;
    logic [9:0]      w_vx_commit;
    logic [9:0]      w_vy_commit;

    // Win is judged on the registered map so it overrides any tick that cycle.
    assign w_bricks_empty = (r_bricks == '0);
    assign w_loss = bus.tick && bus.nxt_dir[0] && (bus.nxt_y >= LOSE_Y);
    // A tick in RUN that commits bricks (ball too unless it is a loss).
    assign w_step = (r_state == S_RUN) && !w_bricks_empty && bus.tick;

`ifdef GAME_FLOW_SPEEDUP_EN
    logic [8:0] r_tick_cnt;
    logic       w_wrap;

    assign w_wrap = w_step && !w_loss && (r_tick_cnt == 9'd511);

    // Count committed ball steps; restart on every serve.
    always_ff @(posedge clk) begin
        if (rst || (w_next == S_SERVE && r_state != S_SERVE))
            r_tick_cnt <= '0;
        else if (w_step && !w_loss)
            r_tick_cnt <= r_tick_cnt + 9'd1;
    end

    // Speed-up stacks on top of the datapath's velocity for that step.
    always_comb begin
        w_vx_commit = bus.nxt_vx;
        w_vy_commit = bus.nxt_vy;
        if (w_wrap) begin
            if (bus.nxt_vx < 10'd8) w_vx_commit = bus.nxt_vx + 10'd1;
            if (bus.nxt_vy < 10'd8) w_vy_commit = bus.nxt_vy + 10'd1;
        end
    end
`else
    assign w_vx_commit = bus.nxt_vx;
    assign w_vy_commit = bus.nxt_vy;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.launch) w_next = S_SERVE;
            S_SERVE: if (bus.launch) w_next = S_RUN;
            S_RUN: begin
                if (w_bricks_empty)  w_next = S_WIN;
                else if (w_loss)     w_next = S_LOSE;
            end
            S_LOSE:  w_next = (r_lives <= 2'd1) ? S_OVER : S_SERVE;
            S_OVER:  if (bus.launch) w_next = S_IDLE;
            S_WIN:   if (bus.launch) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Game datapath registers: load on start, track paddle in serve,
    // commit steps in run, count down lives on loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bricks   <= '0;
            r_ball_x   <= '0;
            r_ball_y   <= '0;
            r_ball_vx  <= '0;
            r_ball_vy  <= '0;
            r_ball_dir <= 2'b00;
            r_lives    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.launch) begin
                        r_bricks  <= bus.init_bricks;
                        r_lives   <= LIVES_Q;
                        r_ball_vx <= SERVE_V;
                        r_ball_vy <= SERVE_V;
                    end
                end
                S_SERVE: begin
                    r_ball_x   <= bus.board_x + 10'd40;
                    r_ball_y   <= SERVE_Y;
                    r_ball_dir <= 2'b10;
                end
                S_RUN: begin
                    if (w_step) begin
                        r_bricks <= bus.nxt_bricks;
                        if (!w_loss) begin
                            r_ball_x   <= bus.nxt_x;
                            r_ball_y   <= bus.nxt_y;
                            r_ball_vx  <= w_vx_commit;
                            r_ball_vy  <= w_vy_commit;
                            r_ball_dir <= bus.nxt_dir;
                        end
                    end
                end
                S_LOSE: begin
                    r_lives <= r_lives - 2'd1;
                    if (r_lives > 2'd1) begin
                        r_ball_vx <= SERVE_V;
                        r_ball_vy <= SERVE_V;
                    end
                end
                default: ;
            endcase
        end
    end

    // End-of-game flags track the state they will appear alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_game_over <= 1'b0;
            r_game_win  <= 1'b0;
        end else begin
            r_game_over <= (w_next == S_OVER);
            r_game_win  <= (w_next == S_WIN);
        end
    end

    assign bus.state     = r_state;
    assign bus.bricks    = r_bricks;
    assign bus.ball_x    = r_ball_x;
    assign bus.ball_y    = r_ball_y;
    assign bus.ball_vx   = r_ball_vx;
    assign bus.ball_vy   = r_ball_vy;
    assign bus.ball_dir  = r_ball_dir;
    assign bus.lives     = r_lives;
    assign bus.game_over = r_game_over;
    assign bus.game_win  = r_game_win;

endmodule
